req_frame_uart_tx: RTL and testbench

//  Downstream stage of the room/sensor menu FSM. Serialises a request frame of two bytes {byte1, byte2}
//  as UART 8N1 on one TX pin, plus an optional checksum byte.

---
 rtl/frame_pkg.sv | 13 +
 rtl/uart_tx_byte.sv | 46 ++++
 rtl/req_frame_uart_tx.sv | 99 +++++++++
 tb/tb_req_frame_uart_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared state type, frame length and baud helper; FRAME_CHECKSUM_EN adds a checksum byte
package frame_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} tx_state_t;
`ifdef FRAME_CHECKSUM_EN
   localparam int FRAME_NBYTES = 3;
`else
   localparam int FRAME_NBYTES = 2;
`endif
   localparam int FRAME_IDX_W = (FRAME_NBYTES > 2) ? 2 : 1;
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one 8N1 byte shifter; can relaunch in the last stop cycle for back-to-back bytes
module uart_tx_byte
   import frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_done
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   tx_state_t     r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          w_bit_end;
   logic          w_ready;
   assign w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);
   assign o_done    = (r_state == STOP) && w_bit_end;
   assign w_ready   = (r_state == IDLE) || o_done;
   assign o_tx      = (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
   // start bit, eight data bits LSB first, stop bit, each held for one baud period
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else if (w_ready) begin
         r_state <= i_start ? START : IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         if (i_start) r_shift <= i_data;
      end else begin
         r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
         if (w_bit_end && r_state == START) r_state <= DATA;
         if (w_bit_end && r_state == DATA) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= STOP;
         end
      end
endmodule

// File: rtl/req_frame_uart_tx.sv
// req_frame_uart_tx: sends {byte1, byte2} (plus byte1^byte2 under FRAME_CHECKSUM_EN) as 8N1 with a done pulse
module req_frame_uart_tx
   import frame_pkg::*;
#(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 115_200,
   parameter int GAP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte1,
   input  logic [7:0] byte2,
   output logic       tx,
   output logic       busy,
   output logic       done_pulse,
   output logic [7:0] frame_cnt
);
   localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD);
   localparam int GAP_CLKS = GAP_BITS * CPB;
   localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
   localparam int GW       = $clog2(GAP_LAST + 1) + 1;
   if (CPB < 2) begin : g_cpb_check
      $error("req_frame_uart_tx: CLKS_PER_BIT must be >= 2");
   end
   // START here means a byte is in flight inside the shifter
   tx_state_t              r_state;
   logic [7:0]             r_b1;
   logic [7:0]             r_b2;
   logic [FRAME_IDX_W-1:0] r_idx;
   logic [GW-1:0]          r_gap;
   logic [FRAME_IDX_W-1:0] w_sel;
   logic [7:0]             w_data;
   logic                   w_accept;
   logic                   w_byte_done;
   logic                   w_last;
   logic                   w_gap_end;
   logic                   w_launch;
   assign w_accept   = (r_state == IDLE) && start;
   assign w_last     = r_idx == FRAME_IDX_W'(FRAME_NBYTES - 1);
   assign w_gap_end  = (r_state == GAP) && (r_gap == GW'(GAP_LAST));
   assign w_launch   = w_accept || w_gap_end ||
                       ((r_state == START) && w_byte_done && !w_last && (GAP_BITS == 0));
   assign busy       = r_state != IDLE;
   assign done_pulse = r_state == DONE;
   // next byte to hand the shifter: byte1 straight from the port on acceptance, else the shadow copy
   always_comb begin
      w_sel = (r_state == GAP) ? r_idx : r_idx + 1'b1;
`ifdef FRAME_CHECKSUM_EN
      w_data = w_accept ? byte1 : (w_sel == 2'd2) ? (r_b1 ^ r_b2) : (w_sel == 2'd1) ? r_b2 : r_b1;
`else
      w_data = w_accept ? byte1 : w_sel[0] ? r_b2 : r_b1;
`endif
   end
   // byte sequencing, inter-byte gap, done cycle and frame counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state   <= IDLE;
         r_b1      <= '0;
         r_b2      <= '0;
         r_idx     <= '0;
         r_gap     <= '0;
         frame_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_b1    <= byte1;
               r_b2    <= byte2;
               r_idx   <= '0;
               r_state <= START;
            end
            START: if (w_byte_done) begin
               if (w_last) r_state <= DONE;
               else begin
                  r_idx   <= r_idx + 1'b1;
                  r_gap   <= '0;
                  r_state <= (GAP_BITS > 0) ? GAP : START;
               end
            end
            GAP: begin
               r_gap <= w_gap_end ? '0 : r_gap + 1'b1;
               if (w_gap_end) r_state <= START;
            end
            DONE: begin
               frame_cnt <= frame_cnt + 1'b1;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   uart_tx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
      .clk    (clk),
      .rst    (rst),
      .i_start(w_launch),
      .i_data (w_data),
      .o_tx   (tx),
      .o_done (w_byte_done)
   );
endmodule

// File: tb/tb_req_frame_uart_tx.sv
// tb_req_frame_uart_tx: directed bench with an independent UART line decoder (CPB=10, GAP_BITS=1)
module tb_req_frame_uart_tx;
   localparam int CPB = 10;
   localparam int GAPB = 1;
`ifdef FRAME_CHECKSUM_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif
   localparam int FLEN = (10 * NB + GAPB * (NB - 1)) * CPB + 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [7:0] byte1 = 8'h00;
   logic [7:0] byte2 = 8'h00;
   logic tx, busy, done_pulse;
   logic [7:0] frame_cnt;
   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] rxq[$];
   int stop_err = 0;
   int dcnt = 0;
   logic dact = 1'b0;
   logic [7:0] dsh = 8'h00;
   req_frame_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .GAP_BITS(GAPB)) dut (
      .clk(clk), .rst(rst), .start(start), .byte1(byte1), .byte2(byte2),
      .tx(tx), .busy(busy), .done_pulse(done_pulse), .frame_cnt(frame_cnt)
   );
   always #5 clk = ~clk;
   // line decoder: samples mid-bit on falling edges, independent of the DUT internals
   always @(negedge clk) begin
      if (rst) dact <= 1'b0;
      else if (!dact) begin
         if (tx == 1'b0) begin
            dact <= 1'b1;
            dcnt <= 1;
         end
      end else begin
         dcnt <= dcnt + 1;
         if (dcnt >= 15 && dcnt <= 85 && dcnt % 10 == 5) dsh[(dcnt - 15) / 10] <= tx;
         if (dcnt == 95) begin
            dact <= 1'b0;
            rxq.push_back(dsh);
            if (tx != 1'b1) stop_err <= stop_err + 1;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] exp_byte(input int i, input logic [7:0] b1, input logic [7:0] b2);
      return (i == 0) ? b1 : (i == 1) ? b2 : (b1 ^ b2);
   endfunction
   task automatic chk_bytes(input string tag, input int frames, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] got;
      chk({tag, "_nbytes"}, rxq.size(), frames * NB);
      for (int i = 0; i < frames * NB; i++) begin
         got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
         chk($sformatf("%s_byte%0d", tag, i), got, exp_byte(i % NB, b1, b2));
      end
      rxq.delete();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rxq.delete();
   endtask
   task automatic run_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                            input bit poke, input int exp_cnt);
      int k;
      byte1 = b1;
      byte2 = b2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      chk({tag, "_tx_lat"}, tx, 1'b0);
      chk({tag, "_busy_lat"}, busy, 1'b1);
      while (!done_pulse && k < 1000) begin
         start = poke && (k == 5 || k == 100);
         if (poke && k == 50) byte1 = 8'hFF;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({tag, "_done_at"}, k, FLEN);
      chk({tag, "_busy_done"}, busy, 1'b1);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done_pulse, 1'b0);
      chk({tag, "_busy_fall"}, busy, 1'b0);
      chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
      chk_bytes(tag, 1, b1, b2);
   endtask
   initial begin
      int k, nd;
      int dt[3];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_tx", tx, 1'b1);
         chk("rst_busy", busy, 1'b0);
         chk("rst_done", done_pulse, 1'b0);
         chk("rst_cnt", frame_cnt, 8'd0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rxq.delete();
      run_frame("single", 8'h06, 8'h00, 1'b0, 1);
      do_reset();
      run_frame("busyign", 8'h06, 8'h00, 1'b1, 1);
      repeat (30) @(negedge clk);
      chk("busyign_idle", busy, 1'b0);
      chk("busyign_norx", rxq.size(), 0);
      chk("busyign_cnt", frame_cnt, 8'd1);
      do_reset();
      byte1 = 8'hA5;
      byte2 = 8'h3C;
      start = 1'b1;
      k = 0;
      nd = 0;
      dt = '{0, 0, 0};
      while (nd < 3 && k < 2000) begin
         @(negedge clk);
         k++;
         if (done_pulse) begin
            dt[nd] = k;
            nd++;
         end
         if (k == FLEN + 1) chk("b2b_idle_gap", busy, 1'b0);
         if (k == FLEN + 2) chk("b2b_rebusy", busy, 1'b1);
      end
      start = 1'b0;
      chk("b2b_first", dt[0], FLEN);
      chk("b2b_spacing1", dt[1] - dt[0], FLEN + 1);
      chk("b2b_spacing2", dt[2] - dt[1], FLEN + 1);
      repeat (3) @(negedge clk);
      chk("b2b_cnt", frame_cnt, 8'd3);
      chk("b2b_idle", busy, 1'b0);
      chk_bytes("b2b", 3, 8'hA5, 8'h3C);
      byte1 = 8'h06;
      byte2 = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("midrst_tx_low", tx, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done_pulse, 1'b0);
      chk("midrst_cnt", frame_cnt, 8'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rxq.delete();
      run_frame("postrst", 8'h06, 8'h00, 1'b0, 1);
`ifdef FRAME_CHECKSUM_EN
      run_frame("cksum", 8'h09, 8'h5A, 1'b0, 2);
`endif
      run_frame("pattern", 8'h81, 8'hC3, 1'b0, 2 + NB - 2);
      chk("stop_bits", stop_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
